// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - opcode/funct encodings, pc_src codes and control bundle for the ID stage
package id_ex_stage_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LB    = 6'h20;
   localparam logic [5:0] OP_LH    = 6'h21;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_LBU   = 6'h24;
   localparam logic [5:0] OP_LHU   = 6'h25;
   localparam logic [5:0] OP_LWU   = 6'h27;
   localparam logic [5:0] OP_SB    = 6'h28;
   localparam logic [5:0] OP_SH    = 6'h29;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FUNCT_JR   = 6'h08;
   localparam logic [5:0] FUNCT_JALR = 6'h09;

   // bit0 of pc_src doubles as the taken/flush indication for fetch
   localparam logic [2:0] PC_SRC_SEQ    = 3'b000;
   localparam logic [2:0] PC_SRC_BRANCH = 3'b001;
   localparam logic [2:0] PC_SRC_JUMP   = 3'b011;
   localparam logic [2:0] PC_SRC_JREG   = 3'b101;

   typedef struct packed {
      logic reg_dst;
      logic alu_src;
      logic mem_read;
      logic mem_write;
      logic mem_to_reg;
      logic reg_write;
      logic link;
   } ctrl_t;

endpackage

// File: rtl/id_ex_stage_register_file.sv
// rtl/id_ex_stage_register_file.sv - 32-entry register file, two operand reads, debug read, write-through bypass
module register_file #(
   parameter int len_data = 32,
   parameter int len_reg  = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [len_reg-1:0]  rs_addr,
   input  logic [len_reg-1:0]  rt_addr,
   input  logic [len_reg-1:0]  debug_addr,
   input  logic                wr_en,
   input  logic [len_reg-1:0]  wr_addr,
   input  logic [len_data-1:0] wr_data,
   output logic [len_data-1:0] rs_data,
   output logic [len_data-1:0] rt_data,
   output logic [len_data-1:0] debug_data
);

   localparam int num_regs = 1 << len_reg;

   logic [len_data-1:0] regs [num_regs];

   // Storage: cleared on reset, written on posedge; r0 is never written
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < num_regs; i++) regs[i] <= '0;
      end else if (wr_en && (wr_addr != '0)) begin
         regs[wr_addr] <= wr_data;
      end
   end

   // Reads see the value being written back this cycle, so WB->ID needs no extra stall
   assign rs_data    = (rs_addr == '0) ? '0 :
                       (wr_en && (wr_addr == rs_addr)) ? wr_data : regs[rs_addr];
   assign rt_data    = (rt_addr == '0) ? '0 :
                       (wr_en && (wr_addr == rt_addr)) ? wr_data : regs[rt_addr];
   assign debug_data = (debug_addr == '0) ? '0 :
                       (wr_en && (wr_addr == debug_addr)) ? wr_data : regs[debug_addr];

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - MIPS decode stage with branch resolution, hazard stall and ID/EX latch
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int len_data = 32,
   parameter int len_reg  = 5
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [len_data-1:0] in_instruction,
   input  logic [len_data-1:0] in_pc_branch,
   input  logic                in_halt_flag,
   input  logic                in_wb_reg_write,
   input  logic [len_reg-1:0]  in_wb_addr,
   input  logic [len_data-1:0] in_wb_data,
   input  logic                in_ex_mem_read,
   input  logic                in_ex_reg_write,
   input  logic [len_reg-1:0]  in_ex_write_reg,
   input  logic [len_reg-1:0]  in_debug_reg_addr,
   output logic [2:0]          out_pc_src,
   output logic [len_data-1:0] out_branch_address,
   output logic [len_data-1:0] out_pc_jump,
   output logic [len_data-1:0] out_pc_register,
   output logic                out_stall_flag,
   output logic [len_data-1:0] out_rs_data,
   output logic [len_data-1:0] out_rt_data,
   output logic [len_data-1:0] out_imm,
   output logic [len_reg-1:0]  out_rs,
   output logic [len_reg-1:0]  out_rt,
   output logic [len_reg-1:0]  out_rd,
   output logic [len_reg-1:0]  out_shamt,
   output logic [5:0]          out_opcode,
   output logic [5:0]          out_funct,
   output logic                out_reg_dst,
   output logic                out_alu_src,
   output logic                out_mem_read,
   output logic                out_mem_write,
   output logic                out_mem_to_reg,
   output logic                out_reg_write,
   output logic                out_link,
   output logic [len_data-1:0] out_pc_link,
   output logic                out_halt_flag,
   output logic [len_data-1:0] out_reg_debug
);

   typedef struct packed {
      ctrl_t               ctrl;
      logic [len_data-1:0] rs_data;
      logic [len_data-1:0] rt_data;
      logic [len_data-1:0] imm;
      logic [len_data-1:0] pc_link;
      logic [len_reg-1:0]  rs;
      logic [len_reg-1:0]  rt;
      logic [len_reg-1:0]  rd;
      logic [len_reg-1:0]  shamt;
      logic [5:0]          opcode;
      logic [5:0]          funct;
   } idex_t;

   logic [5:0]          opcode, funct;
   logic [len_reg-1:0]  rs, rt, rd, shamt, rd_sel;
   logic [15:0]         imm16;
   logic [len_data-1:0] sext_imm, imm_ext, rs_data, rt_data;
   ctrl_t               ctrl;
   logic                is_rtype, is_jr, is_jalr, is_beq, is_bne, is_branch, is_store;
   logic                load_use, branch_hazard;
   idex_t               idex_d, idex_q;

   assign opcode   = in_instruction[31:26];
   assign rs       = in_instruction[25:21];
   assign rt       = in_instruction[20:16];
   assign rd       = in_instruction[15:11];
   assign shamt    = in_instruction[10:6];
   assign funct    = in_instruction[5:0];
   assign imm16    = in_instruction[15:0];
   assign sext_imm = {{(len_data-16){imm16[15]}}, imm16};

   assign is_rtype  = (opcode == OP_RTYPE);
   assign is_jr     = is_rtype && (funct == FUNCT_JR);
   assign is_jalr   = is_rtype && (funct == FUNCT_JALR);
   assign is_beq    = (opcode == OP_BEQ);
   assign is_bne    = (opcode == OP_BNE);
   assign is_branch = is_beq || is_bne;
   assign is_store  = (opcode == OP_SB) || (opcode == OP_SH) || (opcode == OP_SW);

   register_file #(.len_data(len_data), .len_reg(len_reg)) u_regfile (
      .clk        (clk),
      .reset      (reset),
      .rs_addr    (rs),
      .rt_addr    (rt),
      .debug_addr (in_debug_reg_addr),
      .wr_en      (in_wb_reg_write),
      .wr_addr    (in_wb_addr),
      .wr_data    (in_wb_data),
      .rs_data    (rs_data),
      .rt_data    (rt_data),
      .debug_data (out_reg_debug)
   );

   // Main decoder: control bundle, extended immediate and destination index
   always_comb begin
      ctrl    = '0;
      imm_ext = sext_imm;
      rd_sel  = rd;
      if (in_instruction != '0) begin
         case (opcode)
            OP_RTYPE: begin
               if (funct != FUNCT_JR) begin
                  ctrl.reg_dst   = 1'b1;
                  ctrl.reg_write = 1'b1;
               end
               ctrl.link = (funct == FUNCT_JALR);
            end
            OP_ADDI, OP_SLTI, OP_LUI: begin
               ctrl.alu_src   = 1'b1;
               ctrl.reg_write = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
               ctrl.alu_src   = 1'b1;
               ctrl.reg_write = 1'b1;
               imm_ext        = {{(len_data-16){1'b0}}, imm16};
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU: begin
               ctrl.mem_read   = 1'b1;
               ctrl.mem_to_reg = 1'b1;
               ctrl.alu_src    = 1'b1;
               ctrl.reg_write  = 1'b1;
            end
            OP_SB, OP_SH, OP_SW: begin
               ctrl.mem_write = 1'b1;
               ctrl.alu_src   = 1'b1;
            end
            OP_JAL: begin
               ctrl.reg_dst   = 1'b1;
               ctrl.reg_write = 1'b1;
               ctrl.link      = 1'b1;
               rd_sel         = '1;
            end
            default: ;
         endcase
      end
   end

   // A load in EX cannot forward in time; the rs field is always treated as a source
   assign load_use = in_ex_mem_read && (in_ex_write_reg != '0) &&
                     ((in_ex_write_reg == rs) ||
                      ((is_rtype || is_branch || is_store) && (in_ex_write_reg == rt)));

   // Branch compare happens in ID, so any ALU result still in EX must land first
   assign branch_hazard = (is_branch || is_jr || is_jalr) && in_ex_reg_write &&
                          (in_ex_write_reg != '0) &&
                          ((in_ex_write_reg == rs) || (is_branch && (in_ex_write_reg == rt)));

   // Gated by reset so a stall releases the moment reset asserts
   assign out_stall_flag = !reset && (load_use || branch_hazard);

   assign out_branch_address = in_pc_branch + {sext_imm[len_data-3:0], 2'b00};
   assign out_pc_jump        = {in_pc_branch[len_data-1:len_data-4], in_instruction[25:0], 2'b00};
   assign out_pc_register    = rs_data;

   // Branch/jump resolution; stays sequential while stalled or in reset
   always_comb begin
      out_pc_src = PC_SRC_SEQ;
      if (!reset && !out_stall_flag) begin
         if ((is_beq && (rs_data == rt_data)) || (is_bne && (rs_data != rt_data)))
            out_pc_src = PC_SRC_BRANCH;
         else if ((opcode == OP_J) || (opcode == OP_JAL))
            out_pc_src = PC_SRC_JUMP;
         else if (is_jr || is_jalr)
            out_pc_src = PC_SRC_JREG;
      end
   end

   assign idex_d = '{ctrl: ctrl, rs_data: rs_data, rt_data: rt_data, imm: imm_ext,
                     pc_link: in_pc_branch, rs: rs, rt: rt, rd: rd_sel, shamt: shamt,
                     opcode: opcode, funct: funct};

   // ID/EX latch: a stall loads an all-zero bubble; halt marker passes through regardless
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idex_q        <= '0;
         out_halt_flag <= 1'b0;
      end else begin
         out_halt_flag <= in_halt_flag;
         idex_q        <= out_stall_flag ? '0 : idex_d;
      end
   end

   assign out_rs_data    = idex_q.rs_data;
   assign out_rt_data    = idex_q.rt_data;
   assign out_imm        = idex_q.imm;
   assign out_rs         = idex_q.rs;
   assign out_rt         = idex_q.rt;
   assign out_rd         = idex_q.rd;
   assign out_shamt      = idex_q.shamt;
   assign out_opcode     = idex_q.opcode;
   assign out_funct      = idex_q.funct;
   assign out_pc_link    = idex_q.pc_link;
   assign out_reg_dst    = idex_q.ctrl.reg_dst;
   assign out_alu_src    = idex_q.ctrl.alu_src;
   assign out_mem_read   = idex_q.ctrl.mem_read;
   assign out_mem_write  = idex_q.ctrl.mem_write;
   assign out_mem_to_reg = idex_q.ctrl.mem_to_reg;
   assign out_reg_write  = idex_q.ctrl.reg_write;
   assign out_link       = idex_q.ctrl.link;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Instruction Decode stage plus the ID/EX pipeline latch of the 5-stage MIPS core.
- Consumes the fetched instruction and PC+4 from the IF/ID latch, and owns the register file.
- Resolves branches and jumps in ID and drives pc_src, the target addresses and the stall to fetch.
- Registers operands, immediates and control bits for the EX stage.

Parameters:
- len_data, 32, datapath and PC width
- len_reg, 5, register index width (32 registers)

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-high
- in_instruction  in  32  instruction from fetch
- in_pc_branch  in  32  PC+4 from IF/ID
- in_halt_flag  in  1  halt marker from fetch
- in_wb_reg_write  in  1  writeback enable
- in_wb_addr  in  5  writeback register
- in_wb_data  in  32  writeback data
- in_ex_mem_read  in  1  instruction in EX is a load
- in_ex_reg_write  in  1  instruction in EX writes a register
- in_ex_write_reg  in  5  destination register of the EX instruction
- in_debug_reg_addr  in  5  debug read index
- out_pc_src  out  3  000 = seq, 001 = branch, 011 = j/jal, 101 = jr/jalr (bit0 = taken/flush)
- out_branch_address  out  32  in_pc_branch + (sext(imm) << 2)
- out_pc_jump  out  32  {in_pc_branch[31:28], target, 2'b00}
- out_pc_register  out  32  rs value (for jr/jalr)
- out_stall_flag  out  1  freezes PC and IF/ID
- out_rs_data, out_rt_data  out  32  registered operands
- out_imm  out  32  registered extended immediate
- out_rs, out_rt, out_rd  out  5  registered register indices
- out_shamt  out  5  registered shift amount
- out_opcode, out_funct  out  6  registered fields, decoded by EX ALU control
- out_reg_dst, out_alu_src, out_mem_read, out_mem_write, out_mem_to_reg, out_reg_write  out  1  registered control
- out_link  out  1  registered; EX selects out_pc_link as the result
- out_pc_link  out  32  registered in_pc_branch
- out_halt_flag  out  1  registered in_halt_flag
- out_reg_debug  out  32  combinational register-file read of in_debug_reg_addr

Behaviour:
- Reset (async): all 32 registers, all registered outputs and out_halt_flag go to 0.
- Register file:
  - write on posedge when in_wb_reg_write and in_wb_addr != 0; r0 reads 0 always
  - read is combinational with write-through bypass: if wb is active, wb_addr == read index and the index != 0, read returns in_wb_data
- Decode (combinational on in_instruction):
  - R-type (op 0): reg_dst=1, reg_write=1, except jr (funct 08), which writes nothing
  - jalr (funct 09): writes rd, link=1
  - addi/slti/andi/ori/xori/lui: alu_src=1, reg_write=1
  - andi/ori/xori: zero-extend immediate; every other opcode sign-extends
  - loads (lb, lh, lw, lbu, lhu, lwu): mem_read=1, mem_to_reg=1, alu_src=1, reg_write=1
  - stores (sb, sh, sw): mem_write=1, alu_src=1
  - beq/bne: no writes
  - j: no writes
  - jal: reg_write=1, link=1, out_rd forced to 31 with reg_dst=1
  - unknown opcode: all control 0 (NOP)
  - instruction 0x00000000: all control 0
- Hazards (combinational):
  - load-use stall: in_ex_mem_read and in_ex_write_reg != 0 and it matches rs, or matches rt for R-type, branch or store
  - branch/jr stall: current instruction is beq, bne, jr or jalr, in_ex_reg_write, and in_ex_write_reg != 0 matches a compared source
  - both conditions assert out_stall_flag
- Branch resolution (uses bypassed register-file values):
  - beq taken when rs == rt; bne taken when rs != rt
  - while stalled, out_pc_src = 000
- ID/EX latch (posedge):
  - stall: insert bubble; all control outputs and out_link go to 0, data fields hold don't-care (zero them)
  - otherwise: capture the decoded values
  - out_halt_flag captures in_halt_flag every non-reset cycle, regardless of stall
- Latency:
  - decode to EX outputs: 1 cycle
  - pc_src, targets and stall: 0 cycles (combinational)
- Reset mid-stall: stall clears immediately; the latch holds a bubble.

Decomposition:
- Package: opcode/funct localparams, PC_SRC_SEQ/BRANCH/JUMP/JREG encodings, control-bundle field order.
- Sub-module register_file (32x32, 2 read ports, 1 write port, debug read port, bypass).
- Decoder and hazard logic stay inline.

Test Plan:
- Reset, then write r5 = 0x0000_00AA via WB; decode add r3,r5,r0 (0x00A01820) -> next cycle out_rs_data = 0xAA, reg_write = 1, reg_dst = 1, out_rd = 3.
- Same-cycle WB r7 = 0x1234 and decode addi r2,r7,-1 -> out_rs_data = 0x1234, out_imm = 0xFFFFFFFF, alu_src = 1.
- ori r1,r0,0x8001 -> out_imm = 0x0000_8001. Write r0 = 5 -> debug read of r0 = 0.
- EX holds lw into r4 (ex_mem_read = 1, ex_write_reg = 4); decode add r6,r4,r4 -> stall = 1 and a bubble latched. The next cycle with ex_mem_read = 0 -> normal capture.
- r1 = r2 = 9, beq r1,r2,+3 with in_pc_branch = 0x10 -> pc_src = 001, branch_address = 0x1C; with r2 = 8 -> pc_src = 000.
- jal 0x40 at in_pc_branch = 0x24 -> pc_src = 011, pc_jump = 0x100, out_rd = 31, out_pc_link = 0x24. Assert reset mid-stall -> all outputs 0 asynchronously.
